ann_layer_sequencer: RTL
========================

// Module: ann_layer_sequencer
// PURPOSE
//  Layer-by-layer sequencer for the 3-layer ANN datapath (shared node array + pipeline register).
//  Waits for start and loaded image, fetches each layer's coefficients via handshake, clears and
//  steps the node accumulators through that layer's inputs, then latches node outputs into the
//  pipeline register. Signals done after layer 3. Sits between the top-level ANN and coefficient loader.
// PARAMETERS
//  IMAGE_SIZE    64  inputs to layer 1 (pixels)
//  FIRST_LAYER   16  layer-1 nodes = layer-2 inputs
//  SECOND_LAYER  8   layer-2 nodes = layer-3 inputs
//  THIRD_LAYER   10  output nodes (informational; not used in counting)
//  CNT_W         7   input_num width; must hold IMAGE_SIZE-1
// PORTS
//  clk                  in   1      system clock, rising edge
//  n_rst                in   1      reset, synchronous, active-low
//  start_detecting      in   1      request to classify current image
//  image_weights_loaded in   1      image (and memory) ready to load
//  coef_ack             in   1      requested layer's weights valid on coef bus
//  abort                in   1      synchronous cancel, returns to IDLE
//  request_coef         out  1      coefficient request, held until coef_ack
//  coef_select          out  2      layer being requested/processed: 0=L1, 1=L2, 2=L3
//  reset_accum          out  1      clear node accumulators (1-cycle pulse)
//  acc_en               out  1      node accumulate enable (node start)
//  input_num            out  CNT_W  index of input being accumulated
//  load_next            out  3      pipeline reg load: 0=hold, 4=image, 1/2/3=node_out after layer
//  busy                 out  1      high in every state except IDLE
//  done_processing      out  1      1-cycle pulse after layer-3 latch
// BEHAVIOUR
//  - Reset (n_rst low at clk edge): state=IDLE, layer=0, counter=0; all outputs 0.
//  - All outputs decoded from registered state/layer/counter (Moore); no input->output comb paths.
//  - States: IDLE, WAIT_IMG, LOAD_IMG, REQ_COEF, CLEAR, ACCUM, LATCH, DONE.
//    IDLE: start_detecting=1 -> WAIT_IMG; layer<=0.
//    WAIT_IMG: image_weights_loaded=1 -> LOAD_IMG.
//    LOAD_IMG: load_next=4 one cycle -> REQ_COEF.
//    REQ_COEF: request_coef=1, coef_select=layer; coef_ack=1 sampled -> CLEAR.
//    CLEAR: reset_accum=1, counter<=0 -> ACCUM.
//    ACCUM: acc_en=1, input_num=counter; counter=max_in-1 -> LATCH, else counter++.
//      max_in: layer0=IMAGE_SIZE, layer1=FIRST_LAYER, layer2=SECOND_LAYER.
//    LATCH: load_next=layer+1; layer==2 -> DONE, else layer++ and -> REQ_COEF.
//    DONE: done_processing=1 -> IDLE.
//  - coef_select = layer in all states from REQ_COEF to LATCH; 0 elsewhere.
//  - input_num = 0 outside ACCUM; never exceeds max_in-1 (no wrap).
//  - Latency, inputs held high, start sampled at cycle 0: LOAD_IMG @2, L1 ACCUM 5..68,
//    LATCH(1) @69, L2 ACCUM 72..87, LATCH(2) @88, L3 ACCUM 91..98, LATCH(3) @99, DONE @100.
//  - coef_ack low: stay in REQ_COEF indefinitely, request_coef and coef_select stable.
//  - coef_ack outside REQ_COEF, start_detecting while busy: ignored.
//  - abort=1: any state -> IDLE next cycle; no LATCH/done issued; has priority over all
//    transitions. Reset identical but also clears layer/counter.
//  - Simultaneous start_detecting and abort in IDLE: stay IDLE.
// STRUCTURE
//  - Package ann_pkg: seq_state_t enum; LOAD_HOLD/LOAD_IMG/LOAD_L1..L3 codes; COEF_L1..L3 codes.
//  - Sub-module layer_input_counter: clear, enable, max_in -> count, last flag (CNT_W wide).
//  - Top: state register, layer register, next-state and output decode.
// TESTING
//  1. Full run, coef_ack tied 1: start @0 -> load_next=4 @2, =1 @69, =2 @88, =3 @99, done @100 only.
//  2. coef_ack delayed 5 cycles per layer -> request_coef high exactly 6 cycles each, done @115.
//  3. input_num trace: L1 0..63, L2 0..15, L3 0..7, each once, acc_en high 88 cycles total.
//  4. abort in L2 ACCUM (input_num=7) -> IDLE next cycle, no load_next=2, no done; restart OK.
//  5. n_rst low mid L1 ACCUM -> all outputs 0 next edge; start ignored while n_rst low.
//  6. start pulsed during busy and while image_weights_loaded=0 -> no effect / waits in WAIT_IMG.

Source files
------------

// File: rtl/ann_pkg.sv
// Package: ann_pkg
// Shared types and codes for the ANN layer sequencer.
//  seq_state_t           sequencer FSM states
//  LOAD_HOLD..LOAD_L3    pipeline-register load codes driven on load_next
//  COEF_L1..COEF_L3      layer codes driven on coef_select
//  load_code_for_layer   maps a layer code to its pipeline-register load code
package ann_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IMG,
    ST_LOAD_IMG,
    ST_REQ_COEF,
    ST_CLEAR,
    ST_ACCUM,
    ST_LATCH,
    ST_DONE
  } seq_state_t;

  localparam logic [2:0] LOAD_HOLD = 3'd0;
  localparam logic [2:0] LOAD_L1   = 3'd1;
  localparam logic [2:0] LOAD_L2   = 3'd2;
  localparam logic [2:0] LOAD_L3   = 3'd3;
  localparam logic [2:0] LOAD_IMG  = 3'd4;

  localparam logic [1:0] COEF_L1 = 2'd0;
  localparam logic [1:0] COEF_L2 = 2'd1;
  localparam logic [1:0] COEF_L3 = 2'd2;

  // The node outputs of layer N are loaded into the pipeline register with code N+1.
  function automatic logic [2:0] load_code_for_layer(input logic [1:0] layer);
    logic [2:0] code;
    case (layer)
      COEF_L1: code = LOAD_L1;
      COEF_L2: code = LOAD_L2;
      default: code = LOAD_L3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ann_layer_sequencer_layer_input_counter.sv
// Module: layer_input_counter
// Counts the input index being accumulated for the current layer. The count
// stops at max_in-1 and holds there (no wrap) until cleared.
//  clk     in   1      system clock, rising edge
//  n_rst   in   1      synchronous active-low reset
//  clear   in   1      force count to 0 (priority over enable)
//  enable  in   1      advance count by one unless already at max_in-1
//  max_in  in   CNT_W  number of inputs of the current layer
//  count   out  CNT_W  current input index
//  last    out  1      count equals max_in-1
module layer_input_counter
  import ann_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] max_in,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign last  = (count_reg == (max_in - CNT_W'(1)));
  assign count = count_reg;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && !last) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/ann_layer_sequencer.sv
// Module: ann_layer_sequencer
// Layer-by-layer sequencer for the 3-layer ANN datapath. After start and a
// loaded image it latches the image into the pipeline register, then for each
// layer fetches coefficients by handshake, clears the node accumulators, steps
// them through the layer's inputs and latches the node outputs. done_processing
// pulses after the third layer. All outputs are decoded from registered state.
//  clk                  in   1      system clock, rising edge
//  n_rst                in   1      synchronous active-low reset
//  start_detecting      in   1      request to classify the current image
//  image_weights_loaded in   1      image ready to load
//  coef_ack             in   1      requested layer's coefficients valid
//  abort                in   1      synchronous cancel back to IDLE
//  request_coef         out  1      coefficient request, held until coef_ack
//  coef_select          out  2      layer being requested/processed
//  reset_accum          out  1      clear node accumulators
//  acc_en               out  1      node accumulate enable
//  input_num            out  CNT_W  index of input being accumulated
//  load_next            out  3      pipeline register load code
//  busy                 out  1      high outside IDLE
//  done_processing      out  1      one-cycle completion pulse
module ann_layer_sequencer
  import ann_pkg::*;
#(
  parameter int IMAGE_SIZE   = 64,
  parameter int FIRST_LAYER  = 16,
  parameter int SECOND_LAYER = 8,
  parameter int THIRD_LAYER  = 10,
  parameter int CNT_W        = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start_detecting,
  input  logic             image_weights_loaded,
  input  logic             coef_ack,
  input  logic             abort,
  output logic             request_coef,
  output logic [1:0]       coef_select,
  output logic             reset_accum,
  output logic             acc_en,
  output logic [CNT_W-1:0] input_num,
  output logic [2:0]       load_next,
  output logic             busy,
  output logic             done_processing
);

  seq_state_t       state_reg;
  seq_state_t       state_next;
  logic [1:0]       layer_reg;
  logic [1:0]       layer_next;

  logic [CNT_W-1:0] layer_size [4];
  logic [CNT_W-1:0] max_in;
  logic [CNT_W-1:0] count;
  logic             count_last;

  // Width of each layer indexed by layer code. Layer N consumes the outputs
  // of layer N-1, so entry N is the input count of layer N. The last entry
  // (output-layer width) is never selected while counting.
  for (genvar gi = 0; gi < 4; gi++) begin : g_layer_size
    localparam int SIZE = (gi == 0) ? IMAGE_SIZE :
                          (gi == 1) ? FIRST_LAYER :
                          (gi == 2) ? SECOND_LAYER : THIRD_LAYER;
    assign layer_size[gi] = CNT_W'(SIZE);
  end

  assign max_in = layer_size[layer_reg];

  layer_input_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (state_reg == ST_CLEAR),
    .enable (state_reg == ST_ACCUM),
    .max_in (max_in),
    .count  (count),
    .last   (count_last)
  );

  // State and layer registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg <= ST_IDLE;
      layer_reg <= COEF_L1;
    end else begin
      state_reg <= state_next;
      layer_reg <= layer_next;
    end
  end

  // Next-state logic. abort overrides every transition; the layer register is
  // left alone on abort because IDLE->WAIT_IMG reloads it anyway.
  always_comb begin
    state_next = state_reg;
    layer_next = layer_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_detecting) begin
            state_next = ST_WAIT_IMG;
            layer_next = COEF_L1;
          end
        end
        ST_WAIT_IMG: begin
          if (image_weights_loaded) begin
            state_next = ST_LOAD_IMG;
          end
        end
        ST_LOAD_IMG: state_next = ST_REQ_COEF;
        ST_REQ_COEF: begin
          if (coef_ack) begin
            state_next = ST_CLEAR;
          end
        end
        ST_CLEAR: state_next = ST_ACCUM;
        ST_ACCUM: begin
          if (count_last) begin
            state_next = ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (layer_reg == COEF_L3) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_REQ_COEF;
            layer_next = layer_reg + 2'd1;
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    request_coef    = 1'b0;
    coef_select     = COEF_L1;
    reset_accum     = 1'b0;
    acc_en          = 1'b0;
    input_num       = '0;
    load_next       = LOAD_HOLD;
    busy            = (state_reg != ST_IDLE);
    done_processing = 1'b0;
    case (state_reg)
      ST_LOAD_IMG: load_next = LOAD_IMG;
      ST_REQ_COEF: begin
        request_coef = 1'b1;
        coef_select  = layer_reg;
      end
      ST_CLEAR: begin
        reset_accum = 1'b1;
        coef_select = layer_reg;
      end
      ST_ACCUM: begin
        acc_en      = 1'b1;
        input_num   = count;
        coef_select = layer_reg;
      end
      ST_LATCH: begin
        load_next   = load_code_for_layer(layer_reg);
        coef_select = layer_reg;
      end
      ST_DONE: done_processing = 1'b1;
      default: ;
    endcase
  end

endmodule
